// File: rtl/spi_regs_pkg.sv
// Shared definitions for the SPI register slave.
//   NUM_REGS_DEFAULT : number of writable display-source registers
//   spi_state_t      : frame FSM states
//   CMD_*            : bit positions inside the command byte
//   addr_incr_sat    : address increment that sticks at 7
package spi_regs_pkg;

  localparam int unsigned NUM_REGS_DEFAULT = 6;

  localparam int CMD_RW_BIT   = 7;
  localparam int CMD_ADDR_MSB = 2;
  localparam int CMD_ADDR_LSB = 0;

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    DATA
  } spi_state_t;

  function automatic logic [2:0] addr_incr_sat(input logic [2:0] a);
    return (a == 3'd7) ? a : a + 3'd1;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-stage synchroniser with registered edge pulses.
// Ports:
//   clk, reset : system clock, asynchronous active-high reset
//   async_i    : asynchronous input
//   level_o    : synchronised level, aligned with rise_o/fall_o
//   rise_o     : one-cycle pulse on a synchronised 0->1 transition
//   fall_o     : one-cycle pulse on a synchronised 1->0 transition
// RST_VAL sets the value the whole chain powers up with, so an input that
// already sits at RST_VAL after reset produces no edge.
module spi_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic async_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  // sync_q[0] is the first flop; sync_q[SYNC_STAGES-1] is the synchronised
  // level and sync_q[SYNC_STAGES] its previous value for edge detection.
  logic [SYNC_STAGES:0] sync_q;
  logic                 rise_q;
  logic                 fall_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= {(SYNC_STAGES + 1){RST_VAL}};
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-1:0], async_i};
      rise_q <= sync_q[SYNC_STAGES-1] & ~sync_q[SYNC_STAGES];
      fall_q <= ~sync_q[SYNC_STAGES-1] & sync_q[SYNC_STAGES];
    end
  end

  // The delayed level lines up with the registered pulses, so a data input
  // read as level_o is the value seen at the same instant as another
  // instance's edge pulse.
  assign level_o = sync_q[SYNC_STAGES];
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/spi_slave_regs.sv
// SPI mode-0 slave maintaining six 8-bit display-source registers.
// Frame: ss_n low, command byte {rw, 4 ignored bits, addr[2:0]}, data bytes,
// ss_n high. Write data lands at addr, addr+1, ... (saturating at 7);
// addresses >= NUM_REGS are dropped without a strobe.
// Ports:
//   clk, reset           : system clock (>= 8x sclk), async active-high reset
//   sclk, mosi, ss_n     : asynchronous SPI pins, synchronised internally
//   miso                 : SPI data out (0 unless readback is compiled in)
//   slv_reg0..slv_reg5   : register contents
//   wr_strobe, wr_addr   : one-cycle write pulse and the address written
// Optional feature macro: SPI_READBACK_EN enables the miso read path.
module spi_slave_regs
  import spi_regs_pkg::*;
#(
  parameter int unsigned NUM_REGS    = NUM_REGS_DEFAULT,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sclk,
  input  logic       mosi,
  input  logic       ss_n,
  output logic       miso,
  output logic [7:0] slv_reg0,
  output logic [7:0] slv_reg1,
  output logic [7:0] slv_reg2,
  output logic [7:0] slv_reg3,
  output logic [7:0] slv_reg4,
  output logic [7:0] slv_reg5,
  output logic       wr_strobe,
  output logic [2:0] wr_addr
);

  localparam logic [3:0] NUM_REGS_L = 4'(NUM_REGS);

  logic sclk_rise, sclk_fall, sclk_lvl;
  logic mosi_s, mosi_rise, mosi_fall;
  logic ss_rise, ss_fall, ss_lvl;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .reset(reset), .async_i(sclk),
    .level_o(sclk_lvl), .rise_o(sclk_rise), .fall_o(sclk_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .reset(reset), .async_i(mosi),
    .level_o(mosi_s), .rise_o(mosi_rise), .fall_o(mosi_fall)
  );

  // Resetting to 0 means a frame only starts after ss_n is seen high and
  // then falls; a frame interrupted by reset is ignored to its end.
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_ss (
    .clk(clk), .reset(reset), .async_i(ss_n),
    .level_o(ss_lvl), .rise_o(ss_rise), .fall_o(ss_fall)
  );

  spi_state_t state_q;
  logic [2:0] bit_cnt_q;
  logic [6:0] shift_q;
  logic       rw_q;
  logic [2:0] addr_q;
  logic [7:0] regs_q [8];  // entries >= NUM_REGS are never written, read as 0
  logic       wr_strobe_q;
  logic [2:0] wr_addr_q;

  logic [7:0] byte_d;
  logic [2:0] addr_d;
  logic       addr_ok;

  assign byte_d  = {shift_q, mosi_s};
  assign addr_d  = addr_incr_sat(addr_q);
  assign addr_ok = ({1'b0, addr_q} < NUM_REGS_L);

`ifdef SPI_READBACK_EN
  logic [7:0] tx_shift_q;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      rw_q        <= 1'b0;
      addr_q      <= '0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      for (int i = 0; i < 8; i++) regs_q[i] <= '0;
`ifdef SPI_READBACK_EN
      tx_shift_q  <= '0;
`endif
    end else begin
      wr_strobe_q <= 1'b0;
      // Frame start wins over a coincident sclk edge, which is dropped.
      if (ss_fall) begin
        state_q   <= CMD;
        bit_cnt_q <= '0;
`ifdef SPI_READBACK_EN
        tx_shift_q <= '0;
`endif
      end else if (ss_rise) begin
        state_q <= IDLE;
      end else if (sclk_rise && state_q != IDLE) begin
        shift_q   <= byte_d[6:0];
        bit_cnt_q <= bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          if (state_q == CMD) begin
            rw_q    <= byte_d[CMD_RW_BIT];
            addr_q  <= byte_d[CMD_ADDR_MSB:CMD_ADDR_LSB];
            state_q <= DATA;
`ifdef SPI_READBACK_EN
            tx_shift_q <= byte_d[CMD_RW_BIT] ?
                          regs_q[byte_d[CMD_ADDR_MSB:CMD_ADDR_LSB]] : 8'h00;
`endif
          end else begin
            if (!rw_q && addr_ok) begin
              regs_q[addr_q] <= byte_d;
              wr_strobe_q    <= 1'b1;
              wr_addr_q      <= addr_q;
            end
            addr_q <= addr_d;
`ifdef SPI_READBACK_EN
            tx_shift_q <= regs_q[addr_d];
`endif
          end
        end
      end
`ifdef SPI_READBACK_EN
      // The falling edge right after a byte boundary (bit_cnt 0) keeps the
      // freshly loaded MSB on the line for the next byte's first rise.
      else if (sclk_fall && state_q == DATA && bit_cnt_q != 3'd0) begin
        tx_shift_q <= {tx_shift_q[6:0], 1'b0};
      end
`endif
    end
  end

`ifdef SPI_READBACK_EN
  assign miso = (state_q == DATA && rw_q && !ss_n) ? tx_shift_q[7] : 1'b0;
  logic unused_sigs;
  assign unused_sigs = ^{sclk_lvl, mosi_rise, mosi_fall, ss_lvl};
`else
  assign miso = 1'b0;
  logic unused_sigs;
  assign unused_sigs = ^{sclk_lvl, sclk_fall, mosi_rise, mosi_fall, ss_lvl};
`endif

  assign slv_reg0  = regs_q[0];
  assign slv_reg1  = regs_q[1];
  assign slv_reg2  = regs_q[2];
  assign slv_reg3  = regs_q[3];
  assign slv_reg4  = regs_q[4];
  assign slv_reg5  = regs_q[5];
  assign wr_strobe = wr_strobe_q;
  assign wr_addr   = wr_addr_q;

endmodule

// File: doc/spi_slave_regs.md
# spi_slave_regs

SPI-mode-0 slave that receives command/data frames from the external host and maintains the six 8-bit display-source registers `slv_reg0`..`slv_reg5`. It sits directly upstream of the FND display path, which selects one of these registers by switch and drives the 7-segment digits. All SPI pins are asynchronous to `clk` and are synchronised inside the block. Each completed write produces a one-cycle strobe for debug and monitoring.

## Interface
- `NUM_REGS`, 6: number of writable registers; addresses `0..NUM_REGS-1` are valid.
- `SYNC_STAGES`, 2: synchroniser depth on `sclk`, `mosi` and `ss_n`.
- `clk`  in  1  system clock; must be at least 8× the `sclk` frequency.
- `reset`  in  1  asynchronous, active-high reset.
- `sclk`  in  1  SPI clock, idle low (mode 0).
- `mosi`  in  1  SPI data in; MSB first.
- `ss_n`  in  1  slave select, active low; frames the transaction.
- `miso`  out  1  SPI data out; used only when readback is compiled in, otherwise constant 0.
- `slv_reg0`..`slv_reg5`  out  8 each  register contents.
- `wr_strobe`  out  1  one-cycle pulse when a register is written.
- `wr_addr`  out  3  address of the last write; valid while `wr_strobe`=1.

## Operation
- **Frame format:** `ss_n` falls, then a command byte, then zero or more data bytes, then `ss_n` rises.
- **Command byte:**
  - bit7 = `rw` (0 = write, 1 = read).
  - bits[6:3] are ignored.
  - bits[2:0] = start address.
- **Bit sampling:** `mosi` is sampled on the synchronised `sclk` rising edge. A 3-bit bit counter assembles each byte MSB-first.
- **FSM states:** IDLE, CMD, DATA.
  - IDLE→CMD on a synchronised `ss_n` falling edge; the bit counter clears.
  - CMD→DATA after the 8th bit; the address is latched into `addr_q`.
  - DATA: on every 8th bit:
    - If write and `addr_q<NUM_REGS`: `slv_reg[addr_q]` takes the byte, `wr_strobe`=1 and `wr_addr`=`addr_q`.
    - `addr_q` then increments and saturates at 7.
    - Writes to addresses ≥ `NUM_REGS` are discarded and produce no strobe.
  - Any state→IDLE on a synchronised `ss_n` rising edge. A partial byte is discarded and no register changes.
- **Read frames** (`rw`=1) never modify registers.
- **Reset values:** all `slv_reg*`=0x00, `wr_strobe`=0, `wr_addr`=0, `miso`=0, FSM=IDLE.
- **Reset asserted mid-frame:** everything returns to its reset value.
  - The `ss_n` synchroniser resets to 0. A new frame is therefore recognised only after `ss_n` is seen high and then falls.
  - The remainder of an interrupted frame is ignored.
- **`ss_n` falling and `sclk` rising in the same synchronised cycle:** the frame start takes priority and that `sclk` edge is not counted.

## Timing
- Synchroniser delay is `SYNC_STAGES` `clk` cycles, plus 1 cycle for edge detection.
- **Register update:** `slv_regN` and `wr_strobe` update on the `clk` edge following edge detection of the 8th `sclk` rise. With defaults this is 4 `clk` cycles after the physical `sclk` edge.
- **`wr_strobe`:** exactly 1 cycle wide, at most one pulse per byte.
- **Back-to-back frames:** `ss_n` high for at least `SYNC_STAGES`+2 `clk` cycles between frames is required. Shorter gaps may merge frames.

## Configuration
- **`SPI_READBACK_EN` defined:**
  - In a read frame, at the end of the command byte `tx_shift` loads `slv_reg[addr]`, or 0x00 if `addr` ≥ `NUM_REGS`.
  - `miso` presents the MSB immediately and shifts on each synchronised `sclk` falling edge.
  - After each byte, `addr_q` increments and the next register is loaded.
  - `miso`=0 whenever `ss_n` is high.
- **Not defined:** `miso` is tied to 0 and the `tx_shift` logic is absent. Read frames are consumed and ignored.

## Structure
- **Package `spi_regs_pkg`:**
  - `NUM_REGS_DEFAULT`=6.
  - `spi_state_t` enum {IDLE, CMD, DATA}.
  - Constants `CMD_RW_BIT`=7, `CMD_ADDR_MSB`=2, `CMD_ADDR_LSB`=0.
- **Sub-module `spi_sync_edge`:**
  - `SYNC_STAGES`-deep synchroniser with a configurable reset value.
  - Rising- and falling-edge pulse outputs.
  - Instantiated three times, for `sclk`, `mosi` and `ss_n`; the edge outputs on `mosi` are unused.

## Test plan
- **Single write:** reset, then frame {0x02, 0xA5} → `slv_reg2`=0xA5, one `wr_strobe` with `wr_addr`=2, all other registers 0x00.
- **Burst write with overflow:** frame {0x04, 0x11, 0x22, 0x33} → `slv_reg4`=0x11, `slv_reg5`=0x22. The third byte (address 6) is discarded; exactly 2 strobes.
- **Abort mid-byte:** frame {0x01} followed by 5 data bits, then `ss_n` high → `slv_reg1` unchanged and no strobe. The next frame {0x01, 0x3C} writes 0x3C.
- **Reset mid-frame:** `reset` pulses during the data byte of {0x00, 0xFF}. With `ss_n` held low, the remaining bits must produce no write. A later full frame {0x00, 0x7E} → `slv_reg0`=0x7E.
- **Read frame:** {0x83, 0x55} → no register changes. With `SPI_READBACK_EN`, `miso` returns the current `slv_reg3` value MSB-first during the second byte.
- **Clock ratio:** `sclk` = `clk`/8 with random `ss_n` gaps of at least 4 cycles → all writes land correctly across 200 random frames, checked against a reference model.
